// File: rtl/decode_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface   : decode_stage_if                                    |
// | Description : D-register fields, forward sources and decode      |
// |               results for the pipeline decode stage.             |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
interface decode_stage_if;
  logic [3:0]  D_icode_i;
  logic [3:0]  D_rA_i;
  logic [3:0]  D_rB_i;
  logic [63:0] D_valP_i;
  logic [3:0]  e_dstE_i;
  logic [63:0] e_valE_i;
  logic [3:0]  M_dstM_i;
  logic [63:0] m_valM_i;
  logic [3:0]  M_dstE_i;
  logic [63:0] M_valE_i;
  logic [3:0]  W_dstM_i;
  logic [63:0] W_valM_i;
  logic [3:0]  W_dstE_i;
  logic [63:0] W_valE_i;
  logic [3:0]  d_srcA_o;
  logic [3:0]  d_srcB_o;
  logic [3:0]  d_dstE_o;
  logic [3:0]  d_dstM_o;
  logic [63:0] d_valA_o;
  logic [63:0] d_valB_o;

  modport master (
    output D_icode_i, D_rA_i, D_rB_i, D_valP_i,
    output e_dstE_i, e_valE_i, M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
    output W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
    input  d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o, d_valA_o, d_valB_o
  );

  modport slave (
    input  D_icode_i, D_rA_i, D_rB_i, D_valP_i,
    input  e_dstE_i, e_valE_i, M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
    input  W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
    output d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o, d_valA_o, d_valB_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : decode_stage                                       |
// | Description : Pipeline decode: register ids, 15x64 register file,|
// |               operand forwarding. Optional DECODE_DBG_PORT_EN    |
// |               adds a raw register-file debug read port.          |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module decode_stage (
  input  logic           clk_i,
  input  logic           rst_i,
  decode_stage_if.slave  bus
`ifdef DECODE_DBG_PORT_EN
  ,
  input  logic [3:0]     dbg_raddr_i,
  output logic [63:0]    dbg_rdata_o
`endif
);

  localparam logic [3:0] c_NREG     = 4'hF;
  localparam logic [3:0] c_RSP      = 4'h4;
  localparam int         c_NUM_REGS = 15;

  logic [63:0] r_regs [0:c_NUM_REGS-1];

  logic [3:0]  w_src_a;
  logic [3:0]  w_src_b;
  logic [3:0]  w_dst_e;
  logic [3:0]  w_dst_m;
  logic [63:0] w_rf_a;
  logic [63:0] w_rf_b;
  logic [63:0] w_val_a;
  logic [63:0] w_val_b;

  // Register id decode from the instruction code
  always_comb begin
    w_src_a = c_NREG;
    w_src_b = c_NREG;
    w_dst_e = c_NREG;
    w_dst_m = c_NREG;
    case (bus.D_icode_i)
      4'h2: begin w_src_a = bus.D_rA_i; w_dst_e = bus.D_rB_i; end
      4'h3: begin w_dst_e = bus.D_rB_i; end
      4'h4: begin w_src_a = bus.D_rA_i; w_src_b = bus.D_rB_i; end
      4'h5: begin w_src_b = bus.D_rB_i; w_dst_m = bus.D_rA_i; end
      4'h6: begin w_src_a = bus.D_rA_i; w_src_b = bus.D_rB_i; w_dst_e = bus.D_rB_i; end
      4'h8: begin w_src_b = c_RSP; w_dst_e = c_RSP; end
      4'h9: begin w_src_a = c_RSP; w_src_b = c_RSP; w_dst_e = c_RSP; end
      4'hA: begin w_src_a = bus.D_rA_i; w_src_b = c_RSP; w_dst_e = c_RSP; end
      4'hB: begin w_src_a = c_RSP; w_src_b = c_RSP; w_dst_e = c_RSP; w_dst_m = bus.D_rA_i; end
      default: ;
    endcase
  end

  // Array read; NREG has no storage so it falls through to zero
  always_comb begin
    w_rf_a = '0;
    w_rf_b = '0;
    for (int i = 0; i < c_NUM_REGS; i++) begin
      if (w_src_a == 4'(i)) w_rf_a = r_regs[i];
      if (w_src_b == 4'(i)) w_rf_b = r_regs[i];
    end
  end

  // Youngest producer wins; a source whose dst is NREG never matches
  function automatic logic [63:0] fwd_select(input logic [3:0]  src,
                                             input logic [63:0] rf_val);
    logic [63:0] val;
    if (src == c_NREG)                                   val = '0;
    else if (bus.e_dstE_i != c_NREG && bus.e_dstE_i == src) val = bus.e_valE_i;
    else if (bus.M_dstM_i != c_NREG && bus.M_dstM_i == src) val = bus.m_valM_i;
    else if (bus.M_dstE_i != c_NREG && bus.M_dstE_i == src) val = bus.M_valE_i;
    else if (bus.W_dstM_i != c_NREG && bus.W_dstM_i == src) val = bus.W_valM_i;
    else if (bus.W_dstE_i != c_NREG && bus.W_dstE_i == src) val = bus.W_valE_i;
    else                                                 val = rf_val;
    return val;
  endfunction

  always_comb begin
    w_val_b = fwd_select(w_src_b, w_rf_b);
    if (bus.D_icode_i == 4'h7 || bus.D_icode_i == 4'h8)
      w_val_a = bus.D_valP_i;
    else
      w_val_a = fwd_select(w_src_a, w_rf_a);
  end

  assign bus.d_srcA_o = w_src_a;
  assign bus.d_srcB_o = w_src_b;
  assign bus.d_dstE_o = w_dst_e;
  assign bus.d_dstM_o = w_dst_m;
  assign bus.d_valA_o = w_val_a;
  assign bus.d_valB_o = w_val_b;

  // Port M is checked first so it wins when both ports target one register
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < c_NUM_REGS; i++) begin
      if (rst_i)
        r_regs[i] <= '0;
      else if (bus.W_dstM_i == 4'(i))
        r_regs[i] <= bus.W_valM_i;
      else if (bus.W_dstE_i == 4'(i))
        r_regs[i] <= bus.W_valE_i;
    end
  end

`ifdef DECODE_DBG_PORT_EN
  always_comb begin
    dbg_rdata_o = '0;
    for (int i = 0; i < c_NUM_REGS; i++) begin
      if (dbg_raddr_i == 4'(i)) dbg_rdata_o = r_regs[i];
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Single clock clk_i; reset rst_i is synchronous, active-high; all state updates on posedge clk_i.
REQ-002 clk_i  in  1  stage clock.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 D_icode_i  in  4  instruction code from D register.
REQ-005 D_rA_i  in  4  rA field from D register.
REQ-006 D_rB_i  in  4  rB field from D register.
REQ-007 D_valP_i  in  64  next-sequential PC from D register.
REQ-008 e_dstE_i  in  4  execute-stage destE (after cmov cancel).
REQ-009 e_valE_i  in  64  execute-stage ALU result.
REQ-010 M_dstM_i  in  4  memory-stage destM.
REQ-011 m_valM_i  in  64  memory-stage read data.
REQ-012 M_dstE_i  in  4  memory-stage destE.
REQ-013 M_valE_i  in  64  memory-stage valE.
REQ-014 W_dstM_i  in  4  writeback destM; also register-file write port M address.
REQ-015 W_valM_i  in  64  writeback valM; write port M data.
REQ-016 W_dstE_i  in  4  writeback destE; write port E address.
REQ-017 W_valE_i  in  64  writeback valE; write port E data.
REQ-018 d_srcA_o  out  4  source A register id.
REQ-019 d_srcB_o  out  4  source B register id.
REQ-020 d_dstE_o  out  4  destination E register id.
REQ-021 d_dstM_o  out  4  destination M register id.
REQ-022 d_valA_o  out  64  forwarded operand A.
REQ-023 d_valB_o  out  64  forwarded operand B.

Function
REQ-024 Register file: 15 x 64-bit regs, ids 0x0-0xE; id 0xF (NREG) never stored, reads 0.
REQ-025 srcA = rA for icode 2,4,6,A; RSP(4) for 9,B; else NREG.
REQ-026 srcB = rB for icode 4,5,6; RSP for 8,9,A,B; else NREG.
REQ-027 dstE = rB for icode 2,3,6; RSP for 8,9,A,B; else NREG. dstM = rA for icode 5,B; else NREG.
REQ-028 srcA/srcB/dstE/dstM, valA, valB combinational from current inputs and register state (zero-cycle latency).
REQ-029 valA priority: icode 7 or 8 -> D_valP_i; else srcA==NREG -> 0; else first match of e_dstE, M_dstM(m_valM), M_dstE, W_dstM, W_dstE, register file.
REQ-030 valB priority: srcB==NREG -> 0; else same order as REQ-029 excluding the valP case.
REQ-031 Forward-source match ignores sources whose dst equals NREG.
REQ-032 Write: at posedge, reg[W_dstE]<=W_valE and reg[W_dstM]<=W_valM, each skipped when dst==NREG.
REQ-033 W_dstE==W_dstM (non-NREG) in same cycle: W_valM written, W_valE discarded.
REQ-034 Read of a register written same cycle returns old array value; new value reaches valA/valB only via W forward path (REQ-029).

Reset
REQ-035 rst_i high at posedge: all 15 regs cleared to 0; writes that cycle suppressed.
REQ-036 Outputs remain combinational during reset; with all forward dst inputs NREG, valA=valB=0 after reset.

Configuration
REQ-037 Macro DECODE_DBG_PORT_EN defined: adds ports dbg_raddr_i in 4 and dbg_rdata_o out 64, combinational array read, NREG reads 0, no forwarding applied.
REQ-038 Macro undefined: debug ports absent; all other behaviour identical.

Verification
REQ-039 Reset, then icode 6, rA=1, rB=2, all dst NREG -> srcA=1, srcB=2, dstE=2, valA=valB=0.
REQ-040 Write W_dstE=3, W_valE=0x55 one cycle; then icode 2, rA=3 -> valA=0x55 from array; same cycle as write -> 0x55 via W forward.
REQ-041 e_dstE=1 val 0xA, M_dstE=1 val 0xB, W_dstE=1 val 0xC, icode 6 rA=1 -> valA=0xA; drop e_dstE to NREG -> 0xB.
REQ-042 icode 8, D_valP=0x1009, reg4=0x200 -> valA=0x1009, srcB=4, valB=0x200, dstE=4.
REQ-043 W_dstE=4 val 0x10, W_dstM=4 val 0x20 one cycle -> next cycle reg4 reads 0x20.
REQ-044 rst_i asserted with W_dstE=5 val 0x77 -> reg5 stays 0; with DECODE_DBG_PORT_EN, dbg_raddr=5 -> dbg_rdata=0.
